// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StValid,
        StFault
    } fetch_state_e;

    typedef enum logic [1:0] {
        CauseNone       = 2'd0,
        CauseMisaligned = 2'd1,
        CauseBusError   = 2'd2,
        CauseTimeout    = 2'd3
    } fault_cause_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Request timeout counter: counts cycles while start_i is high, flags expired_o after
// TIMEOUT_CYCLES of them and holds until clear_i.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (start_i && !expired_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches the word at pc_i, hands it downstream and drives the next PC.
// Define FETCH_TIMEOUT_EN to build the memory-response watchdog (fault cause 3).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] pc_i,
    output logic [31:0] next_pc_o,
    output logic        pc_update_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o
);

    fetch_state_e state_q;
    fault_cause_e cause_q;
    logic [31:0]  instr_q, instr_pc_q, target_q;
    logic         fault_q, flush_q;

    logic aligned, ack, req_pending, wd_expired;

    assign aligned     = (pc_i[1:0] == 2'b00);
    assign mem_req_o   = (state_q == StReq) && aligned && !wd_expired;
    assign mem_addr_o  = mem_req_o ? pc_i : 32'h0;
    assign ack         = mem_req_o && mem_ack_i;
    // A redirect during an outstanding request must wait for the ack before it can retire.
    assign req_pending = mem_req_o && !mem_ack_i;

`ifdef FETCH_TIMEOUT_EN
    logic wd_start, wd_clear;

    assign wd_start = (state_q == StReq) && aligned && !mem_ack_i;
    assign wd_clear = (state_q != StReq) || mem_ack_i || wd_expired;

    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .start_i   (wd_start),
        .clear_i   (wd_clear),
        .expired_o (wd_expired)
    );
`else
    // No watchdog: a request waits for its ack forever.
    assign wd_expired = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_comb begin
        pc_update_o = 1'b0;
        next_pc_o   = 32'h0;
        unique case (state_q)
            StIdle, StFault: begin
                if (redirect_i) begin
                    pc_update_o = 1'b1;
                    next_pc_o   = redirect_target_i;
                end
            end
            StReq: begin
                if (redirect_i) begin
                    if (!req_pending) begin
                        pc_update_o = 1'b1;
                        next_pc_o   = redirect_target_i;
                    end
                end else if (flush_q && (ack || wd_expired)) begin
                    pc_update_o = 1'b1;
                    next_pc_o   = target_q;
                end
            end
            StValid: begin
                if (redirect_i) begin
                    pc_update_o = 1'b1;
                    next_pc_o   = redirect_target_i;
                end else if (instr_ready_i) begin
                    pc_update_o = 1'b1;
                    next_pc_o   = seq_pc(pc_i);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            cause_q    <= CauseNone;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
            target_q   <= 32'h0;
            fault_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_q <= StReq;
                StReq: begin
                    if (redirect_i && req_pending) begin
                        target_q <= redirect_target_i;
                        flush_q  <= 1'b1;
                    end else if (redirect_i) begin
                        flush_q <= 1'b0;
                    end else if (!aligned) begin
                        fault_q <= 1'b1;
                        cause_q <= CauseMisaligned;
                        state_q <= StFault;
                    end else if (flush_q) begin
                        if (ack || wd_expired) begin
                            flush_q <= 1'b0;
                        end
                    end else if (ack) begin
                        if (mem_err_i) begin
                            fault_q <= 1'b1;
                            cause_q <= CauseBusError;
                            state_q <= StFault;
                        end else begin
                            instr_q    <= mem_rdata_i;
                            instr_pc_q <= pc_i;
                            state_q    <= StValid;
                        end
                    end else if (wd_expired) begin
                        fault_q <= 1'b1;
                        cause_q <= CauseTimeout;
                        state_q <= StFault;
                    end
                end
                StValid: begin
                    if (redirect_i || instr_ready_i) begin
                        state_q <= StReq;
                    end
                end
                StFault: begin
                    if (redirect_i) begin
                        fault_q <= 1'b0;
                        cause_q <= CauseNone;
                        state_q <= StReq;
                    end
                end
            endcase
        end
    end

    assign instr_valid_o = (state_q == StValid);
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a behavioural memory and program counter.
module tb_fetch_unit;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TO         = 4;
    localparam bit          TIMEOUT_ON = 1'b1;
    localparam int          LONG_LAT   = 7;
`else
    localparam int unsigned TO         = 64;
    localparam bit          TIMEOUT_ON = 1'b0;
    localparam int          LONG_LAT   = 40;
`endif
    localparam int NUM_CYCLES = 4000;

    logic        clk, reset_n;
    logic [31:0] pc, next_pc, redirect_target, mem_addr, mem_rdata, instr, instr_pc;
    logic        pc_update, redirect, mem_req, mem_ack, mem_err;
    logic        instr_valid, instr_ready, fault;
    logic [1:0]  fault_cause;

    fetch_unit #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i             (clk),
        .reset_ni          (reset_n),
        .pc_i              (pc),
        .next_pc_o         (next_pc),
        .pc_update_o       (pc_update),
        .redirect_i        (redirect),
        .redirect_target_i (redirect_target),
        .mem_req_o         (mem_req),
        .mem_addr_o        (mem_addr),
        .mem_ack_i         (mem_ack),
        .mem_rdata_i       (mem_rdata),
        .mem_err_i         (mem_err),
        .instr_valid_o     (instr_valid),
        .instr_ready_i     (instr_ready),
        .instr_o           (instr),
        .instr_pc_o        (instr_pc),
        .fault_o           (fault),
        .fault_cause_o     (fault_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // program_counter block
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= 32'h0;
        else if (pc_update) pc <= next_pc;
    end

    typedef enum {PhReset, PhIdle, PhFetch, PhHold, PhFault} ph_e;

    ph_e         ph, cyc_ph;
    logic [31:0] m_pc, m_target, exp_addr;
    bit          m_flush, exp_req, exp_valid, exp_fault, exp_upd;
    int          wait_n, lat, rst_left;
    int          checks, failures;
    logic [31:0] q_upd[$];
    logic [63:0] q_instr[$];
    logic [1:0]  q_fault[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] new_target();
        logic [31:0] t;
        int unsigned r;
        r = $urandom_range(0, 7);
        t = $urandom & 32'hFFFF_FFFC;
        if (r == 0) t = 32'hFFFF_FFFC;
        else if (r == 1) t[1:0] = 2'($urandom_range(1, 3));
        return t;
    endfunction

    task automatic start_fetch();
        ph     = PhFetch;
        wait_n = 0;
        lat    = ($urandom_range(0, 15) == 0) ? LONG_LAT : int'($urandom_range(0, 3));
    endtask

    task automatic do_upd(input logic [31:0] t);
        exp_upd = 1'b1;
        q_upd.push_back(t);
        m_pc = t;
    endtask

    // Driver: memory responder, downstream consumer, redirect source and expectation model.
    initial begin
        logic [31:0] t;
        int r;
        checks = 0; failures = 0;
        reset_n = 1'b0; redirect = 1'b0; redirect_target = 32'h0; mem_ack = 1'b0;
        mem_rdata = 32'h0; mem_err = 1'b0; instr_ready = 1'b0;
        ph = PhReset; cyc_ph = PhReset; rst_left = 3; m_flush = 1'b0; m_pc = 32'h0;
        for (int n = 0; n < NUM_CYCLES; n++) begin
            @(negedge clk);
            if (n == NUM_CYCLES / 2) begin
                ph = PhReset;
                rst_left = 2;
            end
            cyc_ph = ph;
            redirect = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; instr_ready = 1'b0;
            mem_rdata = $urandom; redirect_target = $urandom;
            exp_req = 1'b0; exp_valid = 1'b0; exp_fault = 1'b0; exp_upd = 1'b0; exp_addr = 32'h0;
            case (ph)
                PhReset: begin
                    reset_n = 1'b0;
                    m_pc = 32'h0; m_flush = 1'b0;
                    q_upd.delete(); q_instr.delete(); q_fault.delete();
                    rst_left--;
                    if (rst_left == 0) ph = PhIdle;
                end
                PhIdle: begin
                    reset_n = 1'b1;
                    start_fetch();
                end
                PhFetch: begin
                    if (m_pc[1:0] != 2'b00) begin
                        q_fault.push_back(2'd1);
                        ph = PhFault;
                    end else begin
                        exp_req = 1'b1;
                        exp_addr = m_pc;
                        if (TIMEOUT_ON && wait_n == int'(TO)) begin
                            exp_req = 1'b0;
                            exp_addr = 32'h0;
                            if (m_flush) begin
                                m_flush = 1'b0;
                                do_upd(m_target);
                                start_fetch();
                            end else begin
                                q_fault.push_back(2'd3);
                                ph = PhFault;
                            end
                        end else if (wait_n == lat) begin
                            mem_ack = 1'b1;
                            if (m_flush) begin
                                mem_err = 1'($urandom_range(0, 1));
                                m_flush = 1'b0;
                                do_upd(m_target);
                                start_fetch();
                            end else if ($urandom_range(0, 15) == 0) begin
                                mem_err = 1'b1;
                                q_fault.push_back(2'd2);
                                ph = PhFault;
                            end else begin
                                mem_rdata = mem_word(m_pc);
                                q_instr.push_back({mem_word(m_pc), m_pc});
                                ph = PhHold;
                            end
                        end else begin
                            wait_n++;
                            if ($urandom_range(0, 7) == 0) begin
                                m_target = new_target();
                                redirect = 1'b1;
                                redirect_target = m_target;
                                m_flush = 1'b1;
                            end
                        end
                    end
                end
                PhHold: begin
                    exp_valid = 1'b1;
                    r = int'($urandom_range(0, 7));
                    if (r == 0) begin
                        t = new_target();
                        redirect = 1'b1;
                        redirect_target = t;
                        instr_ready = 1'($urandom_range(0, 1));
                        do_upd(t);
                        start_fetch();
                    end else if (r < 4) begin
                        instr_ready = 1'b1;
                        do_upd(m_pc + 32'd4);
                        start_fetch();
                    end
                end
                PhFault: begin
                    exp_fault = 1'b1;
                    if ($urandom_range(0, 3) == 0) begin
                        t = new_target();
                        redirect = 1'b1;
                        redirect_target = t;
                        do_upd(t);
                        start_fetch();
                    end
                end
                default: ;
            endcase
        end
        #3;
        chk("upd_queue_drained", 32'(q_upd.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor: per-cycle control checks plus scoreboard pops when the DUT presents data.
    initial begin
        bit          have_cur, prev_fault;
        logic [63:0] cur;
        logic [1:0]  cur_cause;
        have_cur = 1'b0; prev_fault = 1'b0; cur = 64'h0; cur_cause = 2'd0;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_ph == PhReset) begin
                chk("rst_mem_req", 32'(mem_req), 32'h0);
                chk("rst_mem_addr", mem_addr, 32'h0);
                chk("rst_instr_valid", 32'(instr_valid), 32'h0);
                chk("rst_instr", instr, 32'h0);
                chk("rst_instr_pc", instr_pc, 32'h0);
                chk("rst_fault", {30'h0, fault_cause} | 32'(fault), 32'h0);
                chk("rst_pc_update", 32'(pc_update), 32'h0);
                chk("rst_next_pc", next_pc, 32'h0);
                have_cur = 1'b0;
                prev_fault = 1'b0;
            end else begin
                chk("mem_req", 32'(mem_req), 32'(exp_req));
                chk("mem_addr", mem_addr, exp_addr);
                chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
                chk("fault", 32'(fault), 32'(exp_fault));
                chk("pc_update", 32'(pc_update), 32'(exp_upd));
                if (pc_update) begin
                    chk("pc_update_expected", 32'(q_upd.size() != 0), 32'h1);
                    if (q_upd.size() != 0) chk("next_pc", next_pc, q_upd.pop_front());
                end
                if (instr_valid) begin
                    if (!have_cur) begin
                        chk("instr_expected", 32'(q_instr.size() != 0), 32'h1);
                        if (q_instr.size() != 0) cur = q_instr.pop_front();
                        have_cur = 1'b1;
                    end
                    chk("instr", instr, cur[63:32]);
                    chk("instr_pc", instr_pc, cur[31:0]);
                    if (instr_ready || redirect) have_cur = 1'b0;
                end
                if (fault && !prev_fault) begin
                    chk("fault_expected", 32'(q_fault.size() != 0), 32'h1);
                    if (q_fault.size() != 0) cur_cause = q_fault.pop_front();
                end
                if (fault) chk("fault_cause", 32'(fault_cause), 32'(cur_cause));
                else chk("fault_cause_clear", 32'(fault_cause), 32'h0);
                prev_fault = fault;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: reads the current PC from `program_counter`, issues a word read to instruction memory and presents the returned instruction downstream with a valid/ready handshake. On each accepted instruction it computes the next PC (sequential or redirect target) and drives it back into `program_counter` through that block's `in`/`available` pair. It also detects misaligned PCs, bus errors and unresponsive memory, and reports them as a fetch fault.

## Interface
- `TIMEOUT_CYCLES`, default 64: cycles `mem_req` may stay high without `mem_ack` before a timeout fault (≥1).

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc` in 32: current PC from `program_counter`.
- `next_pc` out 32: to `program_counter.in`.
- `pc_update` out 1: to `program_counter.available`; single-cycle pulse.
- `redirect` in 1: branch/jump/trap redirect request, single-cycle pulse.
- `redirect_target` in 32: redirect address, valid with `redirect`.
- `mem_req` out 1: instruction memory read request.
- `mem_addr` out 32: read address, equal to `pc` while `mem_req`, else 0.
- `mem_ack` in 1: response strobe; may arrive in the same cycle as `mem_req`.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `mem_err` in 1: bus error, valid only with `mem_ack`.
- `instr_valid` out 1: `instr`/`instr_pc` hold a fetched instruction.
- `instr_ready` in 1: downstream accepts the instruction.
- `instr` out 32: fetched instruction word.
- `instr_pc` out 32: address of `instr`.
- `fault` out 1: sticky fetch fault.
- `fault_cause` out 2: 0 none, 1 misaligned, 2 bus error, 3 timeout.

## Operation
- States: S_IDLE, S_REQ, S_VALID, S_FAULT. Reset enters S_IDLE. S_IDLE moves to S_REQ on the first clock edge after reset release.
- S_REQ, `pc[1:0]`≠0: no request. Set `fault`, cause 1, go to S_FAULT.
- S_REQ, aligned: assert `mem_req`. `pc` is stable here because `pc_update` only pulses on exit.
  - `mem_ack` & !`mem_err`: register `instr`=`mem_rdata` and `instr_pc`=`pc`, go to S_VALID.
  - `mem_ack` & `mem_err`: cause 2, go to S_FAULT.
- A request is never withdrawn before `mem_ack`. `mem_addr` holds its value until ack.
- S_VALID: assert `instr_valid`. `instr`/`instr_pc` stay stable until handshake.
  - On `instr_ready`: pulse `pc_update`, `next_pc`=`redirect` ? `redirect_target` : `pc`+4 (mod 2^32, 0xFFFFFFFC wraps to 0), go to S_REQ.
- Redirect, any state:
  - In S_VALID: drop the held instruction (no handshake), pulse `pc_update` with `next_pc`=`redirect_target`, go to S_REQ.
  - In S_REQ: latch the target and set `flush`. When `mem_ack` arrives, discard data and error. Pulse `pc_update` with the latched target, clear `flush`, stay in S_REQ.
  - A newer redirect overwrites the latched target.
  - In S_FAULT: clear `fault` and `fault_cause`, pulse `pc_update` with the target, go to S_REQ.
- S_FAULT: `mem_req`=0 and `instr_valid`=0. Only `redirect` or reset leaves this state.
- Reset values (async): all outputs 0, `flush` 0, timeout counter 0.

## Timing
- Best case: `mem_ack` in the request cycle gives `instr_valid` on the next cycle. Peak rate is one instruction per 2 cycles.
- `pc_update` is combinational from the handshake or redirect. `program_counter` updates on the same edge, so the new `pc` appears in the following S_REQ cycle.
- Reset asserted mid-request abandons the request. Memory must tolerate this.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter runs while `mem_req` is high without `mem_ack`.
  - After `TIMEOUT_CYCLES` such cycles: drop `mem_req`, cause 3, go to S_FAULT.
  - If `flush` is set at that point, take the redirect instead, with no fault.
- Undefined: no counter is built, S_REQ waits indefinitely, and cause 3 is never produced.

## Structure
- `fetch_pkg`: state enum; fault cause enum (NONE, MISALIGNED, BUS_ERROR, TIMEOUT); `INSTR_BYTES`=4.
- One sub-module, `fetch_watchdog`: timeout counter with `start`/`clear`/`expired`, instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Reset, `pc`=0, ack in request cycle with rdata 0x00000013 → next cycle `instr_valid`, `instr`=0x13, `instr_pc`=0; `instr_ready`=1 → `pc_update`, `next_pc`=4, then `mem_addr`=4.
- `instr_ready` low for 3 cycles → `instr`/`instr_pc` stable, no `mem_req`, no `pc_update`.
- `redirect` to 0x100 during S_VALID with `instr_ready`=1 → `next_pc`=0x100, next request `mem_addr`=0x100.
- `redirect` to 0x200 in S_REQ, ack 2 cycles later with 0xDEADBEEF → `instr_valid` never set; `pc_update` with `next_pc`=0x200 in the ack cycle.
- `pc`=0x2 → no `mem_req`, `fault`=1, cause 1; `redirect` to 0x8 → fault clears, `next_pc`=0x8.
- `mem_ack`+`mem_err` → cause 2. With `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, no ack → cause 3 after 4 cycles. Without the macro, `mem_req` stays high indefinitely.
